// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128/192/256 cipher and inverse cipher, one round per clock.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               operation request, sampled only in IDLE
//   mode_i[1:0]           00 AES-128, 01 AES-192, 10 AES-256, 11 rejected
//   decrypt_i             0 cipher, 1 inverse cipher
//   din_i[127:0]          input block, din_i[127:120] is byte 0
//   round_keys_i          full key schedule, round key 0 in the most-significant 128 bits
//   step_en_i, advance_i  single-step mode and its round strobe
//   busy_o, done_o        operation in progress, one-cycle completion pulse
//   dout_o[127:0]         last completed result
//   state_out_o[127:0]    working state register
//   round_o[3:0]          index of the last applied round
//   err_o                 one-cycle pulse on a rejected start
module aes_round_engine #(
    parameter int unsigned MAX_NK = 8,
    parameter int unsigned MAX_NR = MAX_NK + 6
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [1:0]                  mode_i,
    input  logic                        decrypt_i,
    input  logic [127:0]                din_i,
    input  logic [(MAX_NR+1)*128-1:0]   round_keys_i,
    input  logic                        step_en_i,
    input  logic                        advance_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [127:0]                dout_o,
    output logic [127:0]                state_out_o,
    output logic [3:0]                  round_o,
    output logic                        err_o
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

    // GF(2^8) multiply by x, polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    // FIPS-197 S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; state[r][c] is byte 4c+r
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    // MixColumns / InvMixColumns with circulant coefficient row k
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [7:0] k [4];
        logic [7:0] a [4];
        logic [7:0] b;
        logic [127:0] o;
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(k[(j - r + 4) % 4], a[j]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        end
        return o;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   nr_q, nr_d;
    logic         dec_q, dec_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [3:0]   nr_start_c;
    logic         mode_ok_c;
    logic         adv_c;
    logic [3:0]   rnext_c;
    logic         last_c;
    logic [3:0]   rk_idx_c;
    logic [127:0] rk_c;
    logic [127:0] sb_c, isb_c;
    logic [127:0] enc_sr_c, enc_out_c, dec_ark_c, dec_out_c, round_out_c;

    // Round count for the requested key size; sizes beyond MAX_NR are rejected like mode 11
    always_comb begin
        case (mode_i)
            2'd0:    nr_start_c = 4'd10;
            2'd1:    nr_start_c = 4'd12;
            2'd2:    nr_start_c = 4'd14;
            default: nr_start_c = 4'd0;
        endcase
        mode_ok_c = (mode_i != 2'd3) && (nr_start_c <= 4'(MAX_NR));
    end

    assign adv_c   = !step_en_i || advance_i;
    assign rnext_c = round_q + 4'd1;
    assign last_c  = (rnext_c == nr_q);

    // Round-key index: initial whitening key in IDLE, schedule position in RUN
    always_comb begin
        rk_idx_c = 4'd0;
        if (fsm_q == S_IDLE) begin
            rk_idx_c = decrypt_i ? nr_start_c : 4'd0;
        end else begin
            rk_idx_c = dec_q ? (nr_q - rnext_c) : rnext_c;
        end
    end

    // Round-key select from the flattened schedule
    always_comb begin
        rk_c = '0;
        for (int unsigned i = 0; i <= MAX_NR; i++) begin
            if (rk_idx_c == 4'(i)) rk_c = round_keys_i[(MAX_NR-i)*128 +: 128];
        end
    end

    // Byte substitution commutes with (Inv)ShiftRows, so both S-box banks read the state directly
    always_comb begin
        sb_c  = '0;
        isb_c = '0;
        for (int b = 0; b < 16; b++) begin
            sb_c[127-8*b -: 8]  = sbox(state_q[127-8*b -: 8]);
            isb_c[127-8*b -: 8] = inv_sbox(state_q[127-8*b -: 8]);
        end
    end

    assign enc_sr_c    = shift_rows(sb_c, 1'b0);
    assign enc_out_c   = (last_c ? enc_sr_c : mix_cols(enc_sr_c, 1'b0)) ^ rk_c;
    assign dec_ark_c   = shift_rows(isb_c, 1'b1) ^ rk_c;
    assign dec_out_c   = last_c ? dec_ark_c : mix_cols(dec_ark_c, 1'b1);
    assign round_out_c = dec_q ? dec_out_c : enc_out_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            dout_q  <= '0;
            round_q <= '0;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (start_i && mode_ok_c) fsm_d = S_RUN;
            S_RUN:   if (adv_c && last_c) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Register next values per state
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        round_d = round_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_ok_c) begin
                        state_d = din_i ^ rk_c;
                        round_d = 4'd0;
                        nr_d    = nr_start_c;
                        dec_d   = decrypt_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (adv_c) begin
                    state_d = round_out_c;
                    round_d = rnext_c;
                    if (last_c) begin
                        dout_d = round_out_c;
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o      = (fsm_q == S_RUN);
    assign done_o      = done_q;
    assign dout_o      = dout_q;
    assign state_out_o = state_q;
    assign round_o     = round_q;
    assign err_o       = err_q;

endmodule
